// File: rtl/div_result_display.sv
// div_result_display: captures signed divider results on Rdy rise, double-dabbles them to BCD, drives HEX0..HEX5 (active-low, Sel picks quotient/remainder), Busy while converting, Valid when display is current
module div_result_display (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        Rdy,
  input  logic [15:0] Quotient,
  input  logic [15:0] Remainder,
  input  logic        V,
  input  logic        Sel,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        Busy,
  output logic        Valid
);
  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;
  state_t state, state_nx;
  logic rdy_d, cap, last, sq, sr;
  logic [15:0] sh, mr;
  logic [19:0] bcd, adj, bcd_nx;
  logic [3:0] cnt;
  logic [41:0] seg_q, seg_r, disp;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction
  function automatic logic [41:0] fmt(input logic [19:0] b, input logic s);
    logic [41:0] r;
    logic on;
    r = '1;
    on = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      on = on | (b[i*4+:4] != 4'd0) | (i == 0);
      r[i*7+:7] = on ? seg(b[i*4+:4]) : BLANK;
    end
    r[41:35] = (s && b != 20'd0) ? MINUS : BLANK;
    return r;
  endfunction
  assign cap  = Rdy & ~rdy_d & (state == IDLE);
  assign last = cnt == 4'd15;
  assign Busy = state != IDLE;
  for (genvar n = 0; n < 5; n++) begin : g_adj
    assign adj[n*4+:4] = bcd[n*4+:4] >= 4'd5 ? bcd[n*4+:4] + 4'd3 : bcd[n*4+:4];
  end
  assign bcd_nx = {adj[18:0], sh[15]};
  assign disp = Sel ? seg_r : seg_q;
  assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = disp;
  always_comb begin
    state_nx = state;
    state_nx = (cap && !V) ? CONV_Q :
               (state == CONV_Q && last) ? CONV_R :
               (state == CONV_R && last) ? IDLE : state;
  end
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      rdy_d <= 1'b0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      sh    <= '0;
      mr    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      seg_q <= '1;
      seg_r <= '1;
      Valid <= 1'b0;
    end else begin
      rdy_d <= Rdy;
      if (cap) begin
        if (V) begin
          seg_q <= {6{MINUS}};
          seg_r <= {6{MINUS}};
          Valid <= 1'b1;
        end else begin
          sq    <= Quotient[15];
          sr    <= Remainder[15];
          sh    <= Quotient[15] ? ~Quotient + 16'd1 : Quotient;
          mr    <= Remainder[15] ? ~Remainder + 16'd1 : Remainder;
          bcd   <= '0;
          cnt   <= '0;
          Valid <= 1'b0;
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 4'd1;
        bcd <= last ? 20'd0 : bcd_nx;
        sh  <= last ? mr : {sh[14:0], 1'b0};
        if (last && state == CONV_Q) seg_q <= fmt(bcd_nx, sq);
        if (last && state == CONV_R) begin
          seg_r <= fmt(bcd_nx, sr);
          Valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_result_display.sv
// tb_div_result_display: directed self-checking bench for div_result_display
module tb_div_result_display;
  localparam logic [6:0] BL = 7'h7F, MI = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0, v = 1'b0, sel = 1'b0;
  logic [15:0] q = '0, r = '0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic busy, valid;
  logic [41:0] hex;
  int checks = 0, failures = 0, busy_cnt;
  assign hex = {hex5, hex4, hex3, hex2, hex1, hex0};
  always #5 clk = ~clk;
  div_result_display dut (
    .CLK(clk), .Rst(rst), .Rdy(rdy), .Quotient(q), .Remainder(r), .V(v), .Sel(sel),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .Busy(busy), .Valid(valid)
  );
  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic show(input string tag, input logic [41:0] eq, input logic [41:0] er);
    sel = 1'b0;
    #1 chk({tag, "_q"}, hex, eq);
    sel = 1'b1;
    #1 chk({tag, "_r"}, hex, er);
    sel = 1'b0;
  endtask
  task automatic run_conv(input logic [15:0] qi, input logic [15:0] ri);
    q = qi;
    r = ri;
    v = 1'b0;
    rdy = 1'b1;
    step(33);
    rdy = 1'b0;
    step(1);
    chk("conv_busy", {41'd0, busy}, 42'd0);
    chk("conv_valid", {41'd0, valid}, 42'd1);
  endtask
  initial begin
    step(1);
    chk("rst_hex", hex, {6{BL}});
    chk("rst_busy", {41'd0, busy}, 42'd0);
    chk("rst_valid", {41'd0, valid}, 42'd0);
    rst = 1'b0;
    step(1);
    q = 16'd123;
    r = 16'd4;
    rdy = 1'b1;
    step(1);
    chk("e0_busy", {41'd0, busy}, 42'd1);
    chk("e0_valid", {41'd0, valid}, 42'd0);
    chk("e0_hold", hex, {6{BL}});
    step(16);
    show("e16", {BL, BL, BL, S1, S2, S3}, {6{BL}});
    step(15);
    chk("e31_busy", {41'd0, busy}, 42'd1);
    chk("e31_valid", {41'd0, valid}, 42'd0);
    step(1);
    chk("e32_busy", {41'd0, busy}, 42'd0);
    chk("e32_valid", {41'd0, valid}, 42'd1);
    show("basic", {BL, BL, BL, S1, S2, S3}, {BL, BL, BL, BL, BL, S4});
    rdy = 1'b0;
    step(2);
    run_conv(16'h8000, 16'd0);
    show("minq", {MI, S3, S2, S7, S6, S8}, {BL, BL, BL, BL, BL, S0});
    run_conv(16'd0, 16'hFFF9);
    show("negr", {BL, BL, BL, BL, BL, S0}, {MI, BL, BL, BL, BL, S7});
    v = 1'b1;
    rdy = 1'b1;
    step(1);
    chk("ovf_valid", {41'd0, valid}, 42'd1);
    chk("ovf_busy", {41'd0, busy}, 42'd0);
    show("ovf", {6{MI}}, {6{MI}});
    step(3);
    chk("ovf_busy_late", {41'd0, busy}, 42'd0);
    rdy = 1'b0;
    v = 1'b0;
    step(2);
    q = 16'd55;
    r = 16'd6;
    rdy = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 51; i++) begin
      step(1);
      if (busy) busy_cnt++;
      if (i == 9) rdy = 1'b0;
      if (i == 10) begin
        rdy = 1'b1;
        q = 16'd777;
        r = 16'd8;
      end
    end
    chk("retrig_busy_cycles", 42'(busy_cnt), 42'd32);
    chk("retrig_busy_end", {41'd0, busy}, 42'd0);
    show("retrig", {BL, BL, BL, BL, S5(), S5()}, {BL, BL, BL, BL, BL, S6});
    rdy = 1'b0;
    step(2);
    q = 16'd321;
    r = 16'd1;
    rdy = 1'b1;
    step(20);
    #2 rst = 1'b1;
    #1;
    chk("arst_hex", hex, {6{BL}});
    chk("arst_busy", {41'd0, busy}, 42'd0);
    chk("arst_valid", {41'd0, valid}, 42'd0);
    rdy = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    run_conv(16'd9999, 16'd0);
    show("after_rst", {BL, BL, S9, S9, S9, S9}, {BL, BL, BL, BL, BL, S0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  function automatic logic [6:0] S5();
    return 7'b0010010;
  endfunction
endmodule

// File: doc/div_result_display.md
# div_result_display

Downstream stage of the signed 16-bit divider. Captures the divider's signed Quotient, Remainder and overflow flag when the divider raises Rdy. Converts both magnitudes to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine, then drives six active-low seven-segment digits showing either result, chosen by a select switch.

## Interface
- No parameters; widths fixed at 16-bit signed input and 5 BCD digits plus a sign digit.
- CLK  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Rdy  in  1  divider result-ready level; a rising edge marks a new result.
- Quotient  in  16  signed two's-complement quotient; valid while Rdy=1.
- Remainder  in  16  signed two's-complement remainder; valid while Rdy=1.
- V  in  1  divider overflow flag; valid while Rdy=1.
- Sel  in  1  display select: 0 = quotient, 1 = remainder. Combinational mux over the stored digits; no reconversion.
- HEX0..HEX4  out  7 each  decimal digits, HEX0 = units. Active-low {g,f,e,d,c,b,a}.
- HEX5  out  7  sign digit.
- Busy  out  1  conversion in progress.
- Valid  out  1  displayed digits correspond to the latest captured result.

## Operation
- **Edge detect:** register Rdy_d <= Rdy every cycle. The capture condition is Rdy & ~Rdy_d & (state==IDLE).
- **States:** IDLE, CONV_Q, CONV_R.
- **Capture, V=0:**
  - Store the sign bits sq = Quotient[15] and sr = Remainder[15].
  - Store the magnitudes: mq = sq ? ~Quotient+1 : Quotient, and likewise mr. Magnitudes are 16-bit unsigned, so 0x8000 yields 32768.
  - Clear the 20-bit BCD accumulator and the bit counter.
  - Valid <= 0; state <= CONV_Q.
- **Capture, V=1:**
  - No conversion; state stays IDLE.
  - Both stored digit sets are loaded with six minus signs.
  - Valid <= 1 on the capture edge.
- **CONV_Q / CONV_R:** one iteration per cycle, 16 iterations.
  - Adjust: every BCD nibble >= 5 gets +3.
  - Shift: {bcd, mag} shifts left by 1.
  - After the 16th iteration of CONV_Q: the stored Q digits take the BCD value; the accumulator clears; state <= CONV_R.
  - After the 16th iteration of CONV_R: the stored R digits update; Valid <= 1; state <= IDLE.
- **Display formatting (per stored set):**
  - Leading-zero blanking: digits above the most significant nonzero digit show blank (7'h7F). HEX0 is always shown, so zero displays as "0".
  - HEX5 shows minus (7'b0111111) when the sign bit is set and the magnitude is nonzero; otherwise blank.
  - A negative zero cannot occur, but it would display unsigned.
- **Seven-segment encoding:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Display holding:** the outputs keep showing the previous stored digits during a conversion. They change only when a stored set is updated.
- **Rdy edges while Busy:** ignored; they are not queued. Rdy held high never retriggers.

## Timing
- **Reset values:**
  - HEX0..HEX5 = 7'h7F (blank), Busy = 0, Valid = 0.
  - State = IDLE, Rdy_d = 0, all stored digits and signs = 0/blank.
- **Rdy high at reset release:** because Rdy_d resets to 0, a Rdy held high when reset is released counts as an edge and is captured on the first clock.
- **Latency:** let the capture edge be E0.
  - CONV_Q occupies E1..E16 and the Q digits update at E16.
  - CONV_R occupies E17..E32. The R digits update and Valid rises at E32.
  - Busy is 1 after E0 through E32, and 0 after E32.
- **Overflow path:** Valid and the minus digits appear at E0; Busy stays 0.
- **Sel:** purely combinational; a toggle changes the HEX outputs in the same cycle.
- **Rst mid-conversion:** aborts immediately to the reset values. The next Rdy rising edge starts a fresh capture.

## Test plan
- **Basic conversion:** Rst, then Quotient=123, Remainder=4, V=0, Rdy 0→1.
  - Busy is high for 32 cycles; Valid rises 32 cycles after capture.
  - Sel=0: HEX2,1,0 = 1,2,3; HEX5,4,3 blank.
  - Sel=1: HEX0 = 4, all others blank.
- **Most-negative quotient:** Quotient=0x8000.
  - Sel=0: HEX5 = minus; HEX4..0 = 3,2,7,6,8.
- **Negative remainder:** Quotient=0, Remainder=0xFFF9 (-7).
  - Sel=0: only HEX0 = 0.
  - Sel=1: HEX5 = minus, HEX0 = 7, HEX4..1 blank.
- **Overflow:** V=1 with Rdy rising.
  - All six digits = 0111111 and Valid=1 on the capture edge; Busy never asserts.
- **No retrigger:** Rdy held high for 50 cycles, plus a second 0→1 pulse at cycle 10 of a conversion.
  - Exactly one conversion occurs; the digits reflect the first capture.
- **Reset mid-conversion:** assert Rst at cycle 20 of a conversion.
  - All HEX = 7F, Busy=0, Valid=0, asynchronously.
  - After release, a new Rdy edge with Quotient=9999 shows 9,9,9,9 on HEX3..0.
